axi_req_ctrl: RTL and testbench
===============================

AXI_REQ_CTRL -- requirements
Module: axi_req_ctrl

Interface
REQ-001 Parameter MST_ID, default 2'b01: the mas_sel code that grants this master (2'b01 = master 1, 2'b10 = master 2).
REQ-002 Parameter LEN_W, default 8: width of the burst-length field.
REQ-003 clk  in  1  clock; all flops on the rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 m_awvalid / m_arvalid  in  1 each  master address-valid requests.
REQ-006 m_awlen  in  LEN_W  write burst length minus 1; sampled on AW handshake.
REQ-007 m_wvalid, m_wlast, m_bready, m_rready  in  1 each  master-side handshake signals.
REQ-008 s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast  in  1 each  slave-side handshake signals.
REQ-009 mas_sel  in  2  grant code from the arbiter.
REQ-010 sel_m  out  1  bus request to the arbiter.
REQ-011 endtrans  out  1  one-cycle end-of-transaction pulse to the arbiter.
REQ-012 aw_en / ar_en / w_en  out  1 each  channel pass enables to the interconnect mux.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 len_err  out  1  sticky burst-length mismatch flag.

Function
REQ-015 FSM states: IDLE, REQ, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
REQ-016 IDLE -> REQ when m_awvalid | m_arvalid; the direction is latched at this transition, and write wins if both are high.
REQ-017 REQ -> WADDR or RADDR, per the latched direction, when mas_sel == MST_ID; any other mas_sel value holds REQ.
REQ-018 WADDR: aw_en=1; on m_awvalid & s_awready, latch m_awlen, clear the beat counter, and go to WDATA.
REQ-019 RADDR: ar_en=1; on m_arvalid & s_arready go to RDATA.
REQ-020 WDATA: w_en=1; each m_wvalid & s_wready increments the beat counter; the handshake with m_wlast=1 goes to WRESP.
REQ-021 WRESP -> DONE on s_bvalid & m_bready.
REQ-022 RDATA -> DONE on s_rvalid & m_rready & s_rlast.
REQ-023 DONE: endtrans=1 for exactly one cycle, then the FSM goes to IDLE unconditionally.
REQ-024 Outputs are Moore-decoded from the state register:
- sel_m = (state == REQ)
- endtrans = (state == DONE)
- the enables are high only in their own state.
REQ-025 mas_sel is ignored outside REQ; a grant change mid-transaction does not abort the transaction.
REQ-026 Minimum transaction length, from entering REQ with grant already present: 1 REQ + 1 ADDR + 1 data + 1 resp (write) + 1 DONE cycle.
REQ-027 The beat counter is LEN_W+1 bits and saturates at all-ones; it never wraps.
REQ-028 A new request seen in DONE is not accepted until IDLE (one idle cycle minimum between transactions).

Reset
REQ-029 rstn low forces state to IDLE and clears the latched direction, latched length, beat counter and len_err; this applies at any time, including mid-burst.
REQ-030 During and after reset, all outputs are 0 until a new request arrives.

Configuration
REQ-031 Macro AXI_REQ_BEAT_CHECK_EN: when defined, on the WLAST handshake len_err sets if (beat count including the last beat) != latched awlen+1, and stays set until reset.
REQ-032 When the macro is undefined: no length latch, no beat counter, len_err tied to 0, and WDATA still exits on the m_wlast handshake.

Verification
REQ-033 Write, MST_ID=01: m_awvalid=1, mas_sel=01 after 3 cycles, awlen=3, 4 W beats with WLAST on beat 4, B response -> sel_m high for 4 cycles, single endtrans pulse, len_err=0.
REQ-034 Read: m_arvalid=1, mas_sel=01, 2 R beats with s_rlast on beat 2 -> ar_en for 1 cycle, endtrans 1 cycle after the rlast handshake, FSM returns to IDLE.
REQ-035 m_awvalid=1 and m_arvalid=1 in the same cycle -> write serviced first; a second request (sel_m=1) appears after the IDLE cycle and then the read is serviced.
REQ-036 mas_sel=10 held while MST_ID=01 -> FSM stays in REQ with sel_m=1; switching to 01 -> WADDR next cycle.
REQ-037 rstn pulsed low during WDATA beat 2 -> all outputs 0 immediately, no endtrans pulse, IDLE after release.
REQ-038 With AXI_REQ_BEAT_CHECK_EN: awlen=3 and WLAST on beat 2 -> len_err=1 and sticky; endtrans still pulses after the B response.

Source files
------------

// File: rtl/axi_req_ctrl_if.sv
// Handshake bundle observed by axi_req_ctrl: master-side and slave-side AXI
// channel valid/ready/last signals plus the write burst length.
interface axi_req_ctrl_if #(
    parameter int unsigned LEN_W = 8
);
    logic             m_awvalid;
    logic             m_arvalid;
    logic [LEN_W-1:0] m_awlen;
    logic             m_wvalid;
    logic             m_wlast;
    logic             m_bready;
    logic             m_rready;
    logic             s_awready;
    logic             s_arready;
    logic             s_wready;
    logic             s_bvalid;
    logic             s_rvalid;
    logic             s_rlast;

    // Environment side: drives every handshake signal.
    modport master (
        output m_awvalid, m_arvalid, m_awlen, m_wvalid, m_wlast, m_bready, m_rready,
        output s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast
    );

    // Controller side: only observes the handshakes.
    modport slave (
        input m_awvalid, m_arvalid, m_awlen, m_wvalid, m_wlast, m_bready, m_rready,
        input s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast
    );
endinterface

// File: rtl/axi_req_ctrl.sv
// Per-master AXI request controller: arbitrates for the bus, steers channel enables
// and pulses endtrans. Optional burst-length check enabled by AXI_REQ_BEAT_CHECK_EN.
module axi_req_ctrl #(
    parameter logic [1:0]  MST_ID = 2'b01,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_req_ctrl_if.slave        bus,
    input  logic [1:0]           mas_sel,
    output logic                 sel_m,
    output logic                 endtrans,
    output logic                 aw_en,
    output logic                 ar_en,
    output logic                 w_en,
    output logic                 busy,
    output logic                 len_err
);

    typedef enum logic [2:0] {
        IDLE, REQ, WADDR, WDATA, WRESP, RADDR, RDATA, DONE
    } state_e;

    state_e state_q, state_d;
    logic   dir_wr_q, dir_wr_d;
    logic   sel_m_q, sel_m_d;
    logic   endtrans_q, endtrans_d;
    logic   aw_en_q, aw_en_d;
    logic   ar_en_q, ar_en_d;
    logic   w_en_q, w_en_d;
    logic   busy_q, busy_d;

    logic aw_hs_c, ar_hs_c, w_hs_c, b_hs_c, r_last_hs_c;

    assign aw_hs_c     = bus.m_awvalid & bus.s_awready;
    assign ar_hs_c     = bus.m_arvalid & bus.s_arready;
    assign w_hs_c      = bus.m_wvalid  & bus.s_wready;
    assign b_hs_c      = bus.s_bvalid  & bus.m_bready;
    assign r_last_hs_c = bus.s_rvalid  & bus.m_rready & bus.s_rlast;

`ifdef AXI_REQ_BEAT_CHECK_EN
    localparam int unsigned CNT_W = LEN_W + 1;

    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] beat_inc_c;
    logic [CNT_W-1:0] beats_exp_c;
    logic             len_err_q, len_err_d;

    // Counter saturates at all-ones so an overlong burst can never alias a legal length.
    assign beat_inc_c  = (&beat_q) ? beat_q : beat_q + CNT_W'(1);
    assign beats_exp_c = CNT_W'(len_q) + CNT_W'(1);
    assign len_err     = len_err_q;
`else
    logic unused_awlen;

    assign unused_awlen = ^bus.m_awlen;
    assign len_err      = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        dir_wr_d = dir_wr_q;
`ifdef AXI_REQ_BEAT_CHECK_EN
        len_d     = len_q;
        beat_d    = beat_q;
        len_err_d = len_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.m_awvalid | bus.m_arvalid) begin
                    state_d  = REQ;
                    dir_wr_d = bus.m_awvalid;
                end
            end
            REQ: begin
                if (mas_sel == MST_ID) begin
                    state_d = dir_wr_q ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if (aw_hs_c) begin
                    state_d = WDATA;
`ifdef AXI_REQ_BEAT_CHECK_EN
                    len_d  = bus.m_awlen;
                    beat_d = '0;
`endif
                end
            end
            WDATA: begin
                if (w_hs_c) begin
`ifdef AXI_REQ_BEAT_CHECK_EN
                    beat_d = beat_inc_c;
                    if (bus.m_wlast && (beat_inc_c != beats_exp_c)) begin
                        len_err_d = 1'b1;
                    end
`endif
                    if (bus.m_wlast) begin
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                if (b_hs_c) begin
                    state_d = DONE;
                end
            end
            RADDR: begin
                if (ar_hs_c) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (r_last_hs_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are flops yet track the state register.
        sel_m_d    = (state_d == REQ);
        endtrans_d = (state_d == DONE);
        aw_en_d    = (state_d == WADDR);
        ar_en_d    = (state_d == RADDR);
        w_en_d     = (state_d == WDATA);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            dir_wr_q   <= 1'b0;
            sel_m_q    <= 1'b0;
            endtrans_q <= 1'b0;
            aw_en_q    <= 1'b0;
            ar_en_q    <= 1'b0;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_wr_q   <= dir_wr_d;
            sel_m_q    <= sel_m_d;
            endtrans_q <= endtrans_d;
            aw_en_q    <= aw_en_d;
            ar_en_q    <= ar_en_d;
            w_en_q     <= w_en_d;
            busy_q     <= busy_d;
        end
    end

`ifdef AXI_REQ_BEAT_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            beat_q    <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_q     <= len_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
        end
    end
`endif

    assign sel_m    = sel_m_q;
    assign endtrans = endtrans_q;
    assign aw_en    = aw_en_q;
    assign ar_en    = ar_en_q;
    assign w_en     = w_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_axi_req_ctrl.sv
// Self-checking bench for axi_req_ctrl: transaction-phase reference model checked every
// cycle, directed scenarios with hand-computed counts, then randomized traffic.
module tb_axi_req_ctrl;
    localparam int unsigned LEN_W  = 8;
    localparam logic [1:0]  MST_ID = 2'b01;
    localparam int          SAT    = (1 << (LEN_W + 1)) - 1;
`ifdef AXI_REQ_BEAT_CHECK_EN
    localparam int          CHK    = 1;
`else
    localparam int          CHK    = 0;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic [1:0] mas_sel;
    logic       sel_m, endtrans, aw_en, ar_en, w_en, busy, len_err;

    axi_req_ctrl_if #(.LEN_W(LEN_W)) bus ();

    axi_req_ctrl #(.MST_ID(MST_ID), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .mas_sel  (mas_sel),
        .sel_m    (sel_m),
        .endtrans (endtrans),
        .aw_en    (aw_en),
        .ar_en    (ar_en),
        .w_en     (w_en),
        .busy     (busy),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {sel_m, endtrans, aw_en, ar_en, w_en, busy, len_err};
    endfunction

    // Reference model: which phase of a transaction the master is in, driven by observed handshakes.
    localparam int P_IDLE = 0, P_ARB = 1, P_AW = 2, P_W = 3, P_B = 4, P_AR = 5, P_R = 6, P_END = 7;
    int ph;
    bit m_wr;
    int m_len;
    int m_beats;
    bit m_err;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph <= P_IDLE; m_wr <= 1'b0; m_len <= 0; m_beats <= 0; m_err <= 1'b0;
        end else if (ph == P_IDLE) begin
            if (bus.m_awvalid || bus.m_arvalid) begin
                ph <= P_ARB; m_wr <= bus.m_awvalid;
            end
        end else if (ph == P_ARB) begin
            if (mas_sel == MST_ID) ph <= m_wr ? P_AW : P_AR;
        end else if (ph == P_AW) begin
            if (bus.m_awvalid && bus.s_awready) begin
                ph <= P_W; m_len <= int'(bus.m_awlen); m_beats <= 0;
            end
        end else if (ph == P_W) begin
            if (bus.m_wvalid && bus.s_wready) begin
                m_beats <= m_beats + 1;
                if (bus.m_wlast) begin
                    ph <= P_B;
                    if (CHK == 1 && (((m_beats + 1) > SAT ? SAT : m_beats + 1) != m_len + 1)) m_err <= 1'b1;
                end
            end
        end else if (ph == P_B) begin
            if (bus.s_bvalid && bus.m_bready) ph <= P_END;
        end else if (ph == P_AR) begin
            if (bus.m_arvalid && bus.s_arready) ph <= P_R;
        end else if (ph == P_R) begin
            if (bus.s_rvalid && bus.m_rready && bus.s_rlast) ph <= P_END;
        end else begin
            ph <= P_IDLE;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [6:0] exp_v;
            exp_v = {ph == P_ARB, ph == P_END, ph == P_AW, ph == P_AR, ph == P_W, ph != P_IDLE, m_err};
            chk("outputs", int'(outs()), int'(exp_v));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_awvalid = 0; bus.m_arvalid = 0; bus.m_awlen = '0; bus.m_wvalid = 0;
        bus.m_wlast = 0; bus.m_bready = 0; bus.m_rready = 0; bus.s_awready = 0;
        bus.s_arready = 0; bus.s_wready = 0; bus.s_bvalid = 0; bus.s_rvalid = 0;
        bus.s_rlast = 0; mas_sel = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        step();
    endtask

    function automatic bit rdy(input int stall);
        return (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
    endfunction

    // Reactive environment for one write, one read, or a simultaneous write+read request.
    task automatic txn(input bit do_wr, input bit do_rd, input int len, input int nbeats,
                       input int gdel, input int stall,
                       output int c_sel, output int c_end, output int c_aw, output int c_ar,
                       output int c_w, output int c_busy, output int c_gap, output bit wr_first);
        int  req_cyc = 0, wbeat = 0, rbeat = 0, ends = 0, need;
        bit  aw_hs, ar_hs, w_hs, r_hs, r_last, ar_done = 0, seen = 0;
        logic [1:0] ng;
        c_sel = 0; c_end = 0; c_aw = 0; c_ar = 0; c_w = 0; c_busy = 0; c_gap = 0; wr_first = 0;
        need = int'(do_wr) + int'(do_rd);
        bus.m_awvalid = do_wr; bus.m_arvalid = do_rd; bus.m_awlen = LEN_W'(len);
        for (int cyc = 0; cyc < 400 && ends < need; cyc++) begin
            ng = 2'b10;
            if (stall != 0) begin
                ng = 2'($urandom_range(2));
                if (ng == MST_ID) ng = 2'b11;
            end
            if (sel_m) mas_sel = (req_cyc >= gdel) ? MST_ID : ng;
            else       mas_sel = 2'($urandom);
            bus.s_awready = rdy(stall); bus.s_arready = rdy(stall);
            bus.m_wvalid  = rdy(stall); bus.s_wready  = rdy(stall);
            bus.m_wlast   = (wbeat == nbeats - 1);
            bus.s_bvalid  = rdy(stall); bus.m_bready  = rdy(stall);
            bus.s_rvalid  = rdy(stall); bus.m_rready  = rdy(stall);
            bus.s_rlast   = (rbeat == nbeats - 1);
            aw_hs  = aw_en && bus.m_awvalid && bus.s_awready;
            ar_hs  = ar_en && bus.m_arvalid && bus.s_arready;
            w_hs   = w_en && bus.m_wvalid && bus.s_wready;
            r_hs   = ar_done && bus.s_rvalid && bus.m_rready;
            r_last = bus.s_rlast;
            step();
            c_sel += int'(sel_m); c_end += int'(endtrans); c_aw += int'(aw_en);
            c_ar += int'(ar_en); c_w += int'(w_en); c_busy += int'(busy);
            if (!busy && ends == 1) c_gap++;
            if (!seen && (aw_en || ar_en)) begin seen = 1; wr_first = aw_en; end
            if (sel_m) req_cyc++;
            if (aw_hs) bus.m_awvalid = 0;
            if (ar_hs) begin bus.m_arvalid = 0; ar_done = 1; end
            if (w_hs) wbeat++;
            if (r_hs && !r_last) rbeat++;
            if (endtrans) begin ends++; req_cyc = 0; wbeat = 0; rbeat = 0; ar_done = 0; end
        end
        if (ends < need) chk("txn_timeout", ends, need);
    endtask

    initial begin
        int  c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, n_end;
        bit  wr_first;
        idle_inputs();
        #2 rstn = 1'b0;
        #20 rstn = 1'b1;
        step();
        chk_on = 1'b1;
        chk("reset_outs", int'(outs()), 0);

        // Write, grant after REQ has been seen for 4 cycles, awlen=3 with 4 beats.
        txn(1, 0, 3, 4, 4, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("wr_sel_cycles", c_sel, 4);
        chk("wr_endtrans", c_end, 1);
        chk("wr_aw_cycles", c_aw, 1);
        chk("wr_w_cycles", c_w, 4);
        chk("wr_busy_cycles", c_busy, 11);
        chk("wr_len_err", int'(len_err), 0);
        idle_inputs(); step();
        chk("wr_back_idle", int'(outs()), 0);

        // Read with two R beats.
        txn(0, 1, 0, 2, 1, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("rd_ar_cycles", c_ar, 1);
        chk("rd_endtrans", c_end, 1);
        chk("rd_busy_cycles", c_busy, 5);
        idle_inputs(); step();
        chk("rd_back_idle", int'(busy), 0);

        // Simultaneous write and read: write first, one idle cycle, then the read.
        txn(1, 1, 0, 1, 1, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("both_write_first", int'(wr_first), 1);
        chk("both_endtrans", c_end, 2);
        chk("both_sel_cycles", c_sel, 2);
        chk("both_idle_gap", c_gap, 1);
        idle_inputs(); step();

        // Wrong grant code held for 5 REQ cycles, then granted.
        txn(1, 0, 0, 1, 6, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("nogrant_sel_cycles", c_sel, 6);
        chk("nogrant_busy_cycles", c_busy, 10);
        idle_inputs(); step();

        // Shortest write: grant on the first REQ cycle, single beat.
        txn(1, 0, 0, 1, 1, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("min_busy_cycles", c_busy, 5);
        idle_inputs(); step();

        // Asynchronous reset during the second W beat.
        bus.m_awvalid = 1; bus.m_awlen = 8'd3; mas_sel = MST_ID; bus.s_awready = 1;
        step(); step();
        bus.m_wvalid = 1; bus.s_wready = 1; bus.m_wlast = 0;
        step();
        bus.m_awvalid = 0;
        step();
        chk("rst_mid_w_en", int'(w_en), 1);
        #2 rstn = 1'b0;
        #1 chk("rst_async_outs", int'(outs()), 0);
        n_end = 0;
        repeat (2) begin step(); n_end += int'(endtrans); end
        chk("rst_no_endtrans", n_end, 0);
        idle_inputs();
        rstn = 1'b1;
        step();
        chk("rst_release_idle", int'(outs()), 0);

        // Short burst: awlen=3 but WLAST on beat 2; flag is sticky across a good burst.
        txn(1, 0, 3, 2, 1, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("short_endtrans", c_end, 1);
        chk("short_len_err", int'(len_err), CHK);
        idle_inputs(); step();
        txn(1, 0, 1, 2, 1, 0, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
        chk("len_err_sticky", int'(len_err), CHK);
        idle_inputs(); step();
        do_reset();
        chk("len_err_reset", int'(len_err), 0);

        // Randomized traffic with ready stalls, grant delays and occasional length errors.
        for (int i = 0; i < 60; i++) begin
            int kind, len, nb, gd;
            kind = $urandom_range(2);
            len  = $urandom_range(7);
            nb   = len + 1;
            if (kind != 1 && $urandom_range(3) == 0) nb = $urandom_range(1, 8);
            gd   = $urandom_range(1, 4);
            txn(kind != 1, kind != 0, len, nb, gd, 30, c_sel, c_end, c_aw, c_ar, c_w, c_busy, c_gap, wr_first);
            chk("rand_endtrans", c_end, (kind == 2) ? 2 : 1);
            idle_inputs();
            repeat ($urandom_range(1, 3)) step();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
